// File: rtl/bcd_seg_scan.sv
// Sign + 4-digit BCD display scanner with tear-free frame-boundary update.
// Optional leading-zero blanking enabled by defining BCD_SEG_LZB_EN.
module bcd_seg_scan #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [16:0] bcd,
    input  logic        bcd_vld,
    output logic [6:0]  seg,
    output logic [4:0]  dig_sel,
    output logic        frame_done,
    output logic        upd_ack
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [2:0] IDX_LAST = 3'd4;

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [16:0]      shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic [16:0]      active_q, active_d;
    logic [6:0]       seg_q, seg_d;
    logic [4:0]       dig_sel_q, dig_sel_d;
    logic             frame_done_q, frame_done_d;
    logic             upd_ack_q, upd_ack_d;

    logic div_last;
    logic boundary;
    logic slot_blank;
    logic lz_th, lz_hu, lz_te;
    logic sign_neg;

    function automatic logic [6:0] enc7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h79;
        endcase
        return s;
    endfunction

    // Slot timing: div_cnt runs within a slot, idx walks the five slots.
    always_comb begin
        div_last  = (div_cnt_q == DIV_LAST);
        boundary  = div_last && (idx_q == IDX_LAST);
        div_cnt_d = div_cnt_q + 1'b1;
        idx_d     = idx_q;
        if (div_last) begin
            div_cnt_d = '0;
            idx_d     = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end
    end

    // A word arriving on the boundary cycle bypasses the shadow and commits directly.
    always_comb begin
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        active_d     = active_q;
        frame_done_d = 1'b0;
        upd_ack_d    = 1'b0;
        if (bcd_vld) begin
            shadow_d  = bcd;
            pending_d = 1'b1;
        end
        if (boundary) begin
            frame_done_d = 1'b1;
            if (pending_q || bcd_vld) begin
                active_d  = bcd_vld ? bcd : shadow_q;
                pending_d = 1'b0;
                upd_ack_d = 1'b1;
            end
        end
    end

`ifdef BCD_SEG_LZB_EN
    // A nonzero digit (including >9) stops blanking for every lower digit.
    always_comb begin
        lz_th = (active_q[15:12] == 4'd0);
        lz_hu = lz_th && (active_q[11:8] == 4'd0);
        lz_te = lz_hu && (active_q[7:4] == 4'd0);
    end
`else
    always_comb begin
        lz_th = 1'b0;
        lz_hu = 1'b0;
        lz_te = 1'b0;
    end
`endif

    always_comb begin
        slot_blank = (int'(div_cnt_q) < BLANK_CYC);
        sign_neg   = active_q[16] && (active_q[15:0] != 16'd0);
        seg_d      = '0;
        dig_sel_d  = '0;
        if (!slot_blank) begin
            dig_sel_d = 5'b00001 << idx_q;
            case (idx_q)
                3'd0:    seg_d = enc7(active_q[3:0]);
                3'd1:    seg_d = lz_te ? 7'h00 : enc7(active_q[7:4]);
                3'd2:    seg_d = lz_hu ? 7'h00 : enc7(active_q[11:8]);
                3'd3:    seg_d = lz_th ? 7'h00 : enc7(active_q[15:12]);
                3'd4:    seg_d = sign_neg ? 7'h40 : 7'h00;
                default: seg_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt_q    <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            active_q     <= '0;
            seg_q        <= '0;
            dig_sel_q    <= '0;
            frame_done_q <= 1'b0;
            upd_ack_q    <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            active_q     <= active_d;
            seg_q        <= seg_d;
            dig_sel_q    <= dig_sel_d;
            frame_done_q <= frame_done_d;
            upd_ack_q    <= upd_ack_d;
        end
    end

    assign seg        = seg_q;
    assign dig_sel    = dig_sel_q;
    assign frame_done = frame_done_q;
    assign upd_ack    = upd_ack_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Self-checking bench for bcd_seg_scan (SCAN_DIV=4, BLANK_CYC=1); expected frames queued per update.
module tb_bcd_seg_scan;

    logic        clk;
    logic        rstn;
    logic [16:0] bcd;
    logic        bcd_vld;
    logic [6:0]  seg;
    logic [4:0]  dig_sel;
    logic        frame_done;
    logic        upd_ack;

    int checks;
    int failures;

`ifdef BCD_SEG_LZB_EN
    localparam logic [6:0] Z = 7'h00;
`else
    localparam logic [6:0] Z = 7'h3F;
`endif

    typedef struct {
        logic [16:0]     bcd;
        logic [4:0][6:0] segs;
    } vec_t;

    vec_t            vecs[7];
    logic [4:0][6:0] exp_q[$];

    bcd_seg_scan #(
        .SCAN_DIV (4),
        .BLANK_CYC(1)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bcd       (bcd),
        .bcd_vld   (bcd_vld),
        .seg       (seg),
        .dig_sel   (dig_sel),
        .frame_done(frame_done),
        .upd_ack   (upd_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse(input logic [16:0] v);
        bcd     = v;
        bcd_vld = 1'b1;
        @(negedge clk);
        bcd_vld = 1'b0;
    endtask

    task automatic wait_ack(input string name);
        bit found = 0;
        for (int i = 0; i < 50; i++) begin
            if (upd_ack) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check({name, "_ack_timeout"}, 17'(found), 17'd1);
    endtask

    task automatic wait_frame(input string name);
        bit found = 0;
        for (int i = 0; i < 50; i++) begin
            if (frame_done) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check({name, "_frame_timeout"}, 17'(found), 17'd1);
    endtask

    // Entered on a frame_done cycle; walks one full frame and ends on the next frame_done cycle.
    task automatic check_frame(input string name, input logic exp_ack);
        logic [4:0][6:0] e;
        logic [4:0]      sel;
        if (exp_q.size() == 0) begin
            check({name, "_sb_empty"}, 17'd1, 17'd0);
            return;
        end
        e = exp_q.pop_front();
        check({name, "_fd_start"}, 17'(frame_done), 17'd1);
        check({name, "_ack_start"}, 17'(upd_ack), 17'(exp_ack));
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                sel = 5'b00001 << s;
                if (c == 0) begin
                    check($sformatf("%s_blank_sel_s%0d", name, s), 17'(dig_sel), 17'd0);
                    check($sformatf("%s_blank_seg_s%0d", name, s), 17'(seg), 17'd0);
                end else begin
                    check($sformatf("%s_sel_s%0d_c%0d", name, s, c), 17'(dig_sel), 17'(sel));
                    check($sformatf("%s_seg_s%0d_c%0d", name, s, c), 17'(seg), 17'(e[s]));
                end
                check($sformatf("%s_fd_s%0d_c%0d", name, s, c), 17'(frame_done),
                      17'((s == 4) && (c == 3)));
            end
        end
        check({name, "_ack_end"}, 17'(upd_ack), 17'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rstn     = 1'b0;
        bcd      = '0;
        bcd_vld  = 1'b0;

        vecs[0] = '{17'h0_1234, {7'h00, 7'h06, 7'h5B, 7'h4F, 7'h66}};
        vecs[1] = '{17'h1_0507, {7'h40, Z,     7'h6D, 7'h3F, 7'h07}};
        vecs[2] = '{17'h0_00A5, {7'h00, Z,     Z,     7'h79, 7'h6D}};
        vecs[3] = '{17'h1_0000, {7'h00, Z,     Z,     Z,     7'h3F}};
        vecs[4] = '{17'h1_9876, {7'h40, 7'h6F, 7'h7F, 7'h07, 7'h7D}};
        vecs[5] = '{17'h0_F0F0, {7'h00, 7'h79, 7'h3F, 7'h79, 7'h3F}};
        vecs[6] = '{17'h0_0030, {7'h00, Z,     Z,     7'h4F, 7'h3F}};

        repeat (3) @(negedge clk);
        check("rst_seg", 17'(seg), 17'd0);
        check("rst_sel", 17'(dig_sel), 17'd0);
        check("rst_fd", 17'(frame_done), 17'd0);
        check("rst_ack", 17'(upd_ack), 17'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_blank", 17'(dig_sel), 17'd0);
        @(negedge clk);
        check("post_rst_sel", 17'(dig_sel), 17'h01);
        check("post_rst_seg", 17'(seg), 17'h3F);

        exp_q.push_back({7'h00, Z, Z, Z, 7'h3F});
        wait_frame("idle");
        check_frame("idle", 1'b0);

        for (int i = 0; i < 7; i++) begin
            pulse(vecs[i].bcd);
            exp_q.push_back(vecs[i].segs);
            wait_ack($sformatf("vec%0d", i));
            check_frame($sformatf("vec%0d", i), 1'b1);
        end

        // Two words in one frame: only the last is committed, with a single ack.
        pulse(17'h0_0011);
        @(negedge clk);
        pulse(17'h0_0099);
        exp_q.push_back({7'h00, Z, Z, 7'h6F, 7'h6F});
        wait_ack("last_wins");
        check_frame("last_wins", 1'b1);

        // Word arriving on the boundary cycle itself (frame position 19).
        repeat (19) @(negedge clk);
        check("bnd_pre_ack", 17'(upd_ack), 17'd0);
        pulse(17'h0_0042);
        check("bnd_ack", 17'(upd_ack), 17'd1);
        exp_q.push_back({7'h00, Z, Z, 7'h66, 7'h5B});
        check_frame("bnd", 1'b1);

        // Asynchronous reset in the middle of slot 2.
        repeat (10) @(negedge clk);
        check("mid_pre_sel", 17'(dig_sel), 17'h04);
        #1 rstn = 1'b0;
        #1;
        check("mid_rst_seg", 17'(seg), 17'd0);
        check("mid_rst_sel", 17'(dig_sel), 17'd0);
        check("mid_rst_fd", 17'(frame_done), 17'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("mid_restart_blank", 17'(dig_sel), 17'd0);
        @(negedge clk);
        check("mid_restart_sel", 17'(dig_sel), 17'h01);
        check("mid_restart_seg", 17'(seg), 17'h3F);
        exp_q.push_back({7'h00, Z, Z, Z, 7'h3F});
        wait_frame("mid");
        check_frame("mid", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
